// File: rtl/mask_compaction_sched.sv
// mask_compaction_sched: compacts a 128-lane mask into ascending set-lane indices, OUT_LANES per beat.
// Optional macro MASK_COMPACT_PSUM_PIPE_EN registers the prefix sums and adds a CALC2 stage.

module LFPrefixSum128 (
   input  logic [127:0]      i_mask,
   output logic [127:0][7:0] o_psum
);
   logic [127:0][7:0] w_lvl;
   logic [127:0][7:0] w_nxt;

   // Minimum-depth (Sklansky-form) Ladner-Fischer tree, 7 levels of inclusive prefix sums
   always_comb begin
      w_lvl = '0;
      w_nxt = '0;
      for (int i = 0; i < 128; i++) begin
         w_lvl[7'(i)] = 8'(i_mask[7'(i)]);
      end
      for (int l = 0; l < 7; l++) begin
         w_nxt = w_lvl;
         for (int i = 0; i < 128; i++) begin
            if (((i >> l) & 1) == 1) begin
               w_nxt[7'(i)] = w_lvl[7'(i)] + w_lvl[7'(((i >> (l + 1)) << (l + 1)) + (1 << l) - 1)];
            end
         end
         w_lvl = w_nxt;
      end
   end

   assign o_psum = w_lvl;
endmodule

module mask_compaction_sched #(
   parameter int unsigned OUT_LANES = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [127:0]                 in_mask,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [OUT_LANES*7-1:0]       out_idx,
   output logic [OUT_LANES-1:0]         out_lane_valid,
   output logic                         out_last,
   output logic [7:0]                   out_total
);
   localparam int unsigned LANES = 128;
   localparam int unsigned IDX_W = 7;
   localparam int unsigned TOT_W = 8;
   localparam int unsigned BEATS = LANES / OUT_LANES;
   localparam int unsigned B_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CALC  = 2'd1;
`ifdef MASK_COMPACT_PSUM_PIPE_EN
   localparam logic [1:0] S_CALC2 = 2'd2;
`endif
   localparam logic [1:0] S_EMIT  = 2'd3;

   logic [1:0]                 r_state;
   logic [LANES-1:0]           r_mask_q;
   logic [TOT_W-1:0]           r_total_q;
   logic [B_W-1:0]             r_b;
   logic                       r_out_valid;
   logic [OUT_LANES*IDX_W-1:0] r_out_idx;
   logic [OUT_LANES-1:0]       r_out_lane_valid;
   logic                       r_out_last;
   logic [TOT_W-1:0]           r_out_total;

   logic [1:0]                 w_state_nxt;
   logic [LANES-1:0]           w_mask_nxt;
   logic [TOT_W-1:0]           w_total_nxt;
   logic [B_W-1:0]             w_b_nxt;
   logic                       w_out_valid_nxt;
   logic [OUT_LANES*IDX_W-1:0] w_out_idx_nxt;
   logic [OUT_LANES-1:0]       w_out_lane_valid_nxt;
   logic                       w_out_last_nxt;
   logic [TOT_W-1:0]           w_out_total_nxt;

   logic [LANES-1:0][TOT_W-1:0] w_psum;
   logic [LANES-1:0][TOT_W-1:0] w_psum_src;

   logic [B_W-1:0]             w_beat_b;
   logic [TOT_W-1:0]           w_beat_tot;
   logic [TOT_W-1:0]           w_base;
   logic [TOT_W-1:0]           w_slot;
   logic [OUT_LANES*IDX_W-1:0] w_beat_idx;
   logic [OUT_LANES-1:0]       w_beat_vld;
   logic                       w_beat_last;

   LFPrefixSum128 u_psum (
      .i_mask (r_mask_q),
      .o_psum (w_psum)
   );

`ifdef MASK_COMPACT_PSUM_PIPE_EN
   logic [LANES-1:0][TOT_W-1:0] r_psum_q;

   // Pipeline cut between the adder tree and the index search
   always_ff @(posedge clk) begin
      if (reset) begin
         r_psum_q <= '0;
      end else if (r_state == S_CALC) begin
         r_psum_q <= w_psum;
      end
   end

   assign w_psum_src = r_psum_q;
`else
   assign w_psum_src = w_psum;
`endif

   assign in_ready       = (r_state == S_IDLE) && !reset;
   assign out_valid      = r_out_valid;
   assign out_idx        = r_out_idx;
   assign out_lane_valid = r_out_lane_valid;
   assign out_last       = r_out_last;
   assign out_total      = r_out_total;

   // Contents of the beat to be loaded next: beat 0 from a CALC stage, else r_b+1
   always_comb begin
      w_beat_b    = (r_state == S_EMIT) ? B_W'(r_b + 1'b1) : '0;
      w_beat_tot  = (r_state == S_EMIT) ? r_total_q : w_psum_src[LANES-1];
      w_base      = TOT_W'(w_beat_b) * TOT_W'(OUT_LANES);
      w_beat_last = (9'(w_base) + 9'(OUT_LANES)) >= 9'(w_beat_tot);
      w_slot      = '0;
      w_beat_idx  = '0;
      w_beat_vld  = '0;
      for (int j = 0; j < OUT_LANES; j++) begin
         w_slot        = w_base + TOT_W'(j);
         w_beat_vld[j] = w_slot < w_beat_tot;
         for (int i = 0; i < LANES; i++) begin
            if (r_mask_q[7'(i)] && (w_psum_src[7'(i)] == TOT_W'(w_slot + 8'd1))) begin
               w_beat_idx[j*IDX_W +: IDX_W] = w_beat_idx[j*IDX_W +: IDX_W] | IDX_W'(i);
            end
         end
      end
   end

   always_comb begin
      w_state_nxt          = r_state;
      w_mask_nxt           = r_mask_q;
      w_total_nxt          = r_total_q;
      w_b_nxt              = r_b;
      w_out_valid_nxt      = r_out_valid;
      w_out_idx_nxt        = r_out_idx;
      w_out_lane_valid_nxt = r_out_lane_valid;
      w_out_last_nxt       = r_out_last;
      w_out_total_nxt      = r_out_total;
      case (r_state)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               w_mask_nxt  = in_mask;
               w_b_nxt     = '0;
               w_state_nxt = S_CALC;
            end
         end
`ifdef MASK_COMPACT_PSUM_PIPE_EN
         S_CALC: begin
            w_state_nxt = S_CALC2;
         end
         S_CALC2: begin
`else
         S_CALC: begin
`endif
            w_total_nxt          = w_psum_src[LANES-1];
            w_out_total_nxt      = w_psum_src[LANES-1];
            w_out_valid_nxt      = 1'b1;
            w_out_idx_nxt        = w_beat_idx;
            w_out_lane_valid_nxt = w_beat_vld;
            w_out_last_nxt       = w_beat_last;
            w_state_nxt          = S_EMIT;
         end
         S_EMIT: begin
            if (r_out_valid && out_ready) begin
               if (r_out_last) begin
                  w_out_valid_nxt = 1'b0;
                  w_state_nxt     = S_IDLE;
               end else begin
                  w_b_nxt              = B_W'(r_b + 1'b1);
                  w_out_idx_nxt        = w_beat_idx;
                  w_out_lane_valid_nxt = w_beat_vld;
                  w_out_last_nxt       = w_beat_last;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state          <= S_IDLE;
         r_mask_q         <= '0;
         r_total_q        <= '0;
         r_b              <= '0;
         r_out_valid      <= 1'b0;
         r_out_idx        <= '0;
         r_out_lane_valid <= '0;
         r_out_last       <= 1'b0;
         r_out_total      <= '0;
      end else begin
         r_state          <= w_state_nxt;
         r_mask_q         <= w_mask_nxt;
         r_total_q        <= w_total_nxt;
         r_b              <= w_b_nxt;
         r_out_valid      <= w_out_valid_nxt;
         r_out_idx        <= w_out_idx_nxt;
         r_out_lane_valid <= w_out_lane_valid_nxt;
         r_out_last       <= w_out_last_nxt;
         r_out_total      <= w_out_total_nxt;
      end
   end
endmodule

// File: tb/tb_mask_compaction_sched.sv
// Directed self-checking bench for mask_compaction_sched with OUT_LANES = 8.
module tb_mask_compaction_sched;
   localparam int LAT =
`ifdef MASK_COMPACT_PSUM_PIPE_EN
      3;
`else
      2;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_mask;
   logic         out_valid;
   logic         out_ready;
   logic [55:0]  out_idx;
   logic [7:0]   out_lane_valid;
   logic         out_last;
   logic [7:0]   out_total;

   int n_vec = 0;
   int n_err = 0;

   mask_compaction_sched #(.OUT_LANES(8)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_mask        (in_mask),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_idx        (out_idx),
      .out_lane_valid (out_lane_valid),
      .out_last       (out_last),
      .out_total      (out_total)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Slots 0..n-1 hold start, start+1, ...; remaining slots are 0
   function automatic logic [55:0] seq_idx(input int start, input int n);
      logic [55:0] v;
      v = '0;
      for (int j = 0; j < n; j++) v[j*7 +: 7] = 7'(start + j);
      return v;
   endfunction

   task automatic chk_beat(input string tag, input logic [55:0] idx, input logic [7:0] lv,
                           input logic last, input logic [7:0] tot);
      chk({tag, "_valid"}, out_valid, 1'b1);
      chk({tag, "_idx"}, out_idx, idx);
      chk({tag, "_lanes"}, out_lane_valid, lv);
      chk({tag, "_last"}, out_last, last);
      chk({tag, "_total"}, out_total, tot);
   endtask

   // Offer a mask from IDLE; returns at the negedge of the CALC cycle
   task automatic send_mask(input logic [127:0] m);
      in_mask  = m;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic to_first_beat();
      for (int c = 1; c < LAT; c++) begin
         chk("calc_no_valid", out_valid, 1'b0);
         @(negedge clk);
      end
   endtask

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_mask   = '0;
      out_ready = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_idx", out_idx, 56'h0);
      chk("rst_out_lanes", out_lane_valid, 8'h00);
      chk("rst_out_last", out_last, 1'b0);
      chk("rst_out_total", out_total, 8'h00);
      reset = 1'b0;
      #1;
      chk("rel_in_ready", in_ready, 1'b1);
      @(negedge clk);

      // All ones, streaming
      send_mask({128{1'b1}});
      to_first_beat();
      for (int k = 0; k < 16; k++) begin
         chk_beat($sformatf("ones_b%0d", k), seq_idx(8 * k, 8), 8'hFF, k == 15, 8'd128);
         chk("ones_in_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      chk("ones_done_valid", out_valid, 1'b0);
      chk("ones_done_ready", in_ready, 1'b1);

      // Zero mask
      send_mask('0);
      to_first_beat();
      chk_beat("zero", 56'h0, 8'h00, 1'b1, 8'd0);
      @(negedge clk);
      chk("zero_done_ready", in_ready, 1'b1);
      chk("zero_done_valid", out_valid, 1'b0);

      // Sparse {3,64,127}
      send_mask((128'h1 << 3) | (128'h1 << 64) | (128'h1 << 127));
      to_first_beat();
      chk_beat("sparse", {35'h0, 7'd127, 7'd64, 7'd3}, 8'h07, 1'b1, 8'd3);
      @(negedge clk);

      // Bits 0..8 with backpressure on beat 0
      out_ready = 1'b0;
      send_mask(128'h1FF);
      to_first_beat();
      for (int c = 0; c < 5; c++) begin
         chk_beat($sformatf("bp_hold%0d", c), seq_idx(0, 8), 8'hFF, 1'b0, 8'd9);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk_beat("bp_b1", 56'd8, 8'h01, 1'b1, 8'd9);
      @(negedge clk);
      chk("bp_done_valid", out_valid, 1'b0);

      // Reset during beat 3 of all ones
      send_mask({128{1'b1}});
      to_first_beat();
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk_beat("rstmid_b3", seq_idx(24, 8), 8'hFF, 1'b0, 8'd128);
      reset = 1'b1;
      @(negedge clk);
      chk("rstmid_valid", out_valid, 1'b0);
      chk("rstmid_ready", in_ready, 1'b0);
      reset = 1'b0;
      #1;
      chk("rstmid_rel_ready", in_ready, 1'b1);
      @(negedge clk);
      chk("rstmid_no_beat", out_valid, 1'b0);
      send_mask(128'h1);
      to_first_beat();
      chk_beat("rstmid_new", 56'h0, 8'h01, 1'b1, 8'd1);
      @(negedge clk);

      // in_valid held with changing mask during EMIT
      in_mask  = 128'hFFF;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_mask = {128{1'b1}};
      for (int c = 1; c < LAT; c++) begin
         chk("hold_calc_ready", in_ready, 1'b0);
         @(negedge clk);
      end
      chk_beat("hold_b0", seq_idx(0, 8), 8'hFF, 1'b0, 8'd12);
      chk("hold_b0_ready", in_ready, 1'b0);
      in_mask = 128'hF0;
      @(negedge clk);
      chk_beat("hold_b1", seq_idx(8, 4), 8'h0F, 1'b1, 8'd12);
      chk("hold_b1_ready", in_ready, 1'b0);
      in_mask = 128'h1 << 100;
      @(negedge clk);
      chk("hold_idle_ready", in_ready, 1'b1);
      chk("hold_idle_valid", out_valid, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      to_first_beat();
      chk_beat("hold_next", 56'd100, 8'h01, 1'b1, 8'd1);
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
